risc_v_mike_wb_arbiter: RTL
===========================

RISC_V_MIKE_WB_ARBITER -- requirements
Module: risc_v_mike_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_FILE_DEPTH, default 16, number of architectural registers tracked in pending mask.
REQ-002 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have alu_valid/alu_ready  input/output  1/1  ALU result handshake.
REQ-005 SHALL have alu_rd  input  t_instr_register  ALU destination; alu_data  input  DATA_32_W  ALU result.
REQ-006 SHALL have lsu_valid/lsu_ready  input/output  1/1  load-unit result handshake.
REQ-007 SHALL have lsu_rd  input  t_instr_register  load destination; lsu_data  input  DATA_32_W  load result.
REQ-008 SHALL have reg_file_write  output  1, reg_file_wr_addr  output  t_instr_register, reg_file_wr_data  output  DATA_32_W; these drive the register-file write port.
REQ-009 SHALL have pending_mask  output  REG_FILE_DEPTH  bit n set while any held result targets register n.
REQ-010 SHALL have fwd_rs1/fwd_rs2  input  t_instr_register; fwd_hit_1/fwd_hit_2  output  1; fwd_data_1/fwd_data_2  output  DATA_32_W.

Function
REQ-011 SHALL hold one entry per source (ALU slot, LSU slot): valid, rd, data, age bit.
REQ-012 SHALL accept on valid&ready; slot loaded at that edge, visible the next cycle.
REQ-013 SHALL drive src_ready = slot empty OR slot granted this cycle; ready SHALL NOT depend on src_valid.
REQ-014 SHALL grant at most one occupied slot per cycle; granted slot empties at the edge unless reloaded the same edge.
REQ-015 SHALL arbitrate when both slots are occupied: if rds equal and nonzero, the older entry wins; else round-robin against last_grant flop.
REQ-016 SHALL mark a slot older when it was loaded while the other slot was empty or loaded later; when both load at the same edge, LSU is older.
REQ-017 SHALL drive reg_file_write, addr and data combinationally from the granted slot; latency is accept edge -> write cycle = 1 cycle minimum.
REQ-018 SHALL grant an entry with rd=0 normally but hold reg_file_write=0 for it; pending_mask[0] SHALL always be 0.
REQ-019 SHALL drive reg_file_wr_addr/data to 0 when no grant.
REQ-020 SHALL compute pending_mask combinationally as the OR of decoded rd of valid slots.
REQ-021 SHALL assert fwd_hit_x when a valid slot has rd==fwd_rsx and rd!=0; with two matches, data from the younger slot.
REQ-022 SHALL update last_grant only on a grant; a single occupied slot is always granted.

Reset
REQ-023 SHALL clear both slot valids, age bits, and the data/rd flops to 0 on rst low; last_grant SHALL reset to ALU.
REQ-024 SHALL hold all outputs at 0 during reset, except alu_ready and lsu_ready, which SHALL be 1.
REQ-025 SHALL discard held entries when reset asserts mid-operation; no write is issued after release for them.

Configuration
REQ-026 SHALL compile forwarding logic only under macro MIKE_WB_FWD_EN.
REQ-027 SHALL, without MIKE_WB_FWD_EN, keep fwd ports present, with fwd_hit_x=0 and fwd_data_x=0.

Structure
REQ-028 SHALL put the slot record typedef (valid, rd, data, age) and the grant-source enum (GNT_ALU, GNT_LSU) in risc_v_mike_pkg.
REQ-029 SHALL use the existing header flop macros for all state.
REQ-030 SHALL instantiate one sub-module risc_v_mike_wb_slot per source (load/hold/drain of one entry).

Verification
REQ-031 SHALL cover: ALU only, rd=5, data=0xDEAD_BEEF -> reg_file_write=1, addr 5 next cycle; pending_mask=0x0020 that cycle.
REQ-032 SHALL cover: both valid same edge, rd=3/rd=7 -> LSU rd 3 written first, ALU rd 7 next cycle; alu_ready=0 in between.
REQ-033 SHALL cover: LSU rd=4 held, ALU rd=4 arrives later, same cycle as a competing grant -> LSU data written before ALU data.
REQ-034 SHALL cover: rd=0, data=0x1234 -> slot drains, reg_file_write stays 0, pending_mask=0.
REQ-035 SHALL cover: MIKE_WB_FWD_EN, ALU slot rd=9 data 0x55, fwd_rs2=9 -> fwd_hit_2=1, fwd_data_2=0x55; undefined build -> 0/0.
REQ-036 SHALL cover: rst low with both slots full -> after release, no write is issued, readys=1, pending_mask=0.

Source files
------------

// File: rtl/risc_v_mike_pkg.sv
// Shared types for the mike write-back arbiter: slot record, grant source, forwarding lookup.
// The forwarding helper is only referenced when MIKE_WB_FWD_EN is defined.
package risc_v_mike_pkg;

    localparam int unsigned DATA_32_W  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] t_instr_register;

    typedef struct packed {
        logic                 valid;
        t_instr_register      rd;
        logic [DATA_32_W-1:0] data;
        logic                 age;
    } t_wb_slot;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } t_gnt_src;

    typedef struct packed {
        logic                 hit;
        logic [DATA_32_W-1:0] data;
    } t_fwd_res;

    // The younger of two matching slots carries the newest value; age=1 marks the older slot.
    function automatic t_fwd_res fwd_lookup(t_wb_slot alu, t_wb_slot lsu, t_instr_register rs);
        t_fwd_res res;
        logic     m_alu;
        logic     m_lsu;
        res   = '0;
        m_alu = alu.valid && (alu.rd == rs) && (rs != '0);
        m_lsu = lsu.valid && (lsu.rd == rs) && (rs != '0);
        res.hit = m_alu || m_lsu;
        if (m_alu && m_lsu) begin
            res.data = lsu.age ? alu.data : lsu.data;
        end else if (m_alu) begin
            res.data = alu.data;
        end else if (m_lsu) begin
            res.data = lsu.data;
        end
        return res;
    endfunction

endpackage

// File: rtl/risc_v_mike_wb_slot.sv
// One held write-back entry: loads on accept, drains on grant, tracks its relative age.
module risc_v_mike_wb_slot
    import risc_v_mike_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_drain,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [DATA_32_W-1:0]  i_data,
    input  logic                  i_age_next,
    output logic                  o_valid,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [DATA_32_W-1:0]  o_data,
    output logic                  o_age,
    output logic                  o_ready_c
);

    t_wb_slot r_slot;

    // A reload on the draining edge takes priority so back-to-back results never bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot <= '0;
        end else if (i_load) begin
            r_slot.valid <= 1'b1;
            r_slot.rd    <= i_rd;
            r_slot.data  <= i_data;
            r_slot.age   <= i_age_next;
        end else if (i_drain) begin
            r_slot.valid <= 1'b0;
            r_slot.age   <= 1'b0;
        end else if (r_slot.valid) begin
            r_slot.age   <= i_age_next;
        end
    end

    assign o_valid   = r_slot.valid;
    assign o_rd      = r_slot.rd;
    assign o_data    = r_slot.data;
    assign o_age     = r_slot.age;
    assign o_ready_c = !r_slot.valid || i_drain;

endmodule

// File: rtl/risc_v_mike_wb_arbiter.sv
// Two-source (ALU, LSU) write-back arbiter with pending-register mask and optional forwarding.
// Forwarding is compiled in only when MIKE_WB_FWD_EN is defined; otherwise fwd outputs are tied to 0.
module risc_v_mike_wb_arbiter
    import risc_v_mike_pkg::*;
#(
    parameter int unsigned REG_FILE_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_W-1:0]     alu_rd,
    input  logic [DATA_32_W-1:0]      alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [REG_ADDR_W-1:0]     lsu_rd,
    input  logic [DATA_32_W-1:0]      lsu_data,
    output logic                      reg_file_write,
    output logic [REG_ADDR_W-1:0]     reg_file_wr_addr,
    output logic [DATA_32_W-1:0]      reg_file_wr_data,
    output logic [REG_FILE_DEPTH-1:0] pending_mask,
    input  logic [REG_ADDR_W-1:0]     fwd_rs1,
    input  logic [REG_ADDR_W-1:0]     fwd_rs2,
    output logic                      fwd_hit_1,
    output logic                      fwd_hit_2,
    output logic [DATA_32_W-1:0]      fwd_data_1,
    output logic [DATA_32_W-1:0]      fwd_data_2
);

    logic                  w_alu_valid, w_lsu_valid;
    logic [REG_ADDR_W-1:0] w_alu_rd, w_lsu_rd;
    logic [DATA_32_W-1:0]  w_alu_data, w_lsu_data;
    logic                  w_alu_age, w_lsu_age;
    logic                  w_alu_gnt, w_lsu_gnt, w_any_gnt;
    logic                  w_alu_load, w_lsu_load;
    logic                  w_alu_keep, w_lsu_keep;
    logic                  w_alu_age_next, w_lsu_age_next;
    t_gnt_src              w_gnt_src;
    t_gnt_src              r_last_grant;

    risc_v_mike_wb_slot u_alu_slot (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_alu_load),
        .i_drain    (w_alu_gnt),
        .i_rd       (alu_rd),
        .i_data     (alu_data),
        .i_age_next (w_alu_age_next),
        .o_valid    (w_alu_valid),
        .o_rd       (w_alu_rd),
        .o_data     (w_alu_data),
        .o_age      (w_alu_age),
        .o_ready_c  (alu_ready)
    );

    risc_v_mike_wb_slot u_lsu_slot (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_lsu_load),
        .i_drain    (w_lsu_gnt),
        .i_rd       (lsu_rd),
        .i_data     (lsu_data),
        .i_age_next (w_lsu_age_next),
        .o_valid    (w_lsu_valid),
        .o_rd       (w_lsu_rd),
        .o_data     (w_lsu_data),
        .o_age      (w_lsu_age),
        .o_ready_c  (lsu_ready)
    );

    // Same-register collisions must retire in arrival order; otherwise alternate fairly.
    always_comb begin
        w_gnt_src = GNT_ALU;
        if (w_alu_valid && w_lsu_valid) begin
            if ((w_alu_rd == w_lsu_rd) && (w_alu_rd != '0)) begin
                w_gnt_src = w_lsu_age ? GNT_LSU : GNT_ALU;
            end else begin
                w_gnt_src = (r_last_grant == GNT_ALU) ? GNT_LSU : GNT_ALU;
            end
        end else if (w_lsu_valid) begin
            w_gnt_src = GNT_LSU;
        end
    end

    assign w_any_gnt  = w_alu_valid || w_lsu_valid;
    assign w_alu_gnt  = w_alu_valid && (w_gnt_src == GNT_ALU);
    assign w_lsu_gnt  = w_lsu_valid && (w_gnt_src == GNT_LSU);
    assign w_alu_load = alu_valid && alu_ready;
    assign w_lsu_load = lsu_valid && lsu_ready;
    assign w_alu_keep = w_alu_valid && !w_alu_gnt;
    assign w_lsu_keep = w_lsu_valid && !w_lsu_gnt;

    // A held slot becomes older when the other side loads; a simultaneous load favours LSU.
    assign w_alu_age_next = w_alu_load ? !(w_lsu_load || w_lsu_keep) : (w_lsu_load || w_alu_age);
    assign w_lsu_age_next = w_lsu_load ? !w_alu_keep : (w_alu_load || w_lsu_age);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= GNT_ALU;
        end else if (w_any_gnt) begin
            r_last_grant <= w_gnt_src;
        end
    end

    always_comb begin
        reg_file_write   = 1'b0;
        reg_file_wr_addr = '0;
        reg_file_wr_data = '0;
        if (w_lsu_gnt) begin
            reg_file_write   = (w_lsu_rd != '0);
            reg_file_wr_addr = w_lsu_rd;
            reg_file_wr_data = w_lsu_data;
        end else if (w_alu_gnt) begin
            reg_file_write   = (w_alu_rd != '0);
            reg_file_wr_addr = w_alu_rd;
            reg_file_wr_data = w_alu_data;
        end
    end

    // Bit 0 stays clear: x0 is never a real pending write.
    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 1; i < REG_FILE_DEPTH; i++) begin
            if ((w_alu_valid && (w_alu_rd == REG_ADDR_W'(i))) ||
                (w_lsu_valid && (w_lsu_rd == REG_ADDR_W'(i)))) begin
                pending_mask[i] = 1'b1;
            end
        end
    end

`ifdef MIKE_WB_FWD_EN
    t_wb_slot w_alu_slot, w_lsu_slot;
    t_fwd_res w_fwd_1, w_fwd_2;

    assign w_alu_slot = '{valid: w_alu_valid, rd: w_alu_rd, data: w_alu_data, age: w_alu_age};
    assign w_lsu_slot = '{valid: w_lsu_valid, rd: w_lsu_rd, data: w_lsu_data, age: w_lsu_age};
    assign w_fwd_1    = fwd_lookup(w_alu_slot, w_lsu_slot, fwd_rs1);
    assign w_fwd_2    = fwd_lookup(w_alu_slot, w_lsu_slot, fwd_rs2);
    assign fwd_hit_1  = w_fwd_1.hit;
    assign fwd_data_1 = w_fwd_1.data;
    assign fwd_hit_2  = w_fwd_2.hit;
    assign fwd_data_2 = w_fwd_2.data;
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{fwd_rs1, fwd_rs2};
    assign fwd_hit_1    = 1'b0;
    assign fwd_data_1   = '0;
    assign fwd_hit_2    = 1'b0;
    assign fwd_data_2   = '0;
`endif

endmodule
